// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: decoded-op and result records,
// ALU opcode and divider state enums, branch condition codes.
package ex_stage_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  // Branch condition codes carried in func3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic       use_imm;
    logic       mem_en;
    logic       wb_en;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [2:0] func3;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] value;
  } rd_t;

  typedef struct packed {
    logic [XLEN-1:0] value;
  } rs_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
  } id_ex_t;

  typedef struct packed {
    ctrl_t ctrl;
    rd_t   rd;
    rs_t   rs;
  } ex_mem_t;

  function automatic logic is_div_op(alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-side bundle of the execute stage: decoded op in, result, stall
// and redirect out. master = surrounding pipeline, slave = execute stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic            iStall;
  logic            iFlush;
  id_ex_t          iID;
  ex_mem_t         oME;
  logic            oStall;
  logic            oRedirect;
  logic [XLEN-1:0] oTarget;

  modport master (output iStall, iFlush, iID,
                  input  oME, oStall, oRedirect, oTarget);
  modport slave  (input  iStall, iFlush, iID,
                  output oME, oStall, oRedirect, oTarget);
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring divider: works on operand magnitudes for DIV_STEPS
// cycles, then applies sign fixups and holds the result until released.
module ex_divider
  import ex_stage_pkg::*;
(
  input  logic            iClk,
  input  logic            nRst,
  input  logic            iStart,
  input  logic            iSigned,
  input  logic            iRem,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iAbort,
  input  logic            iHold,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            rem_sel_q, rem_sel_d;

  logic            a_neg, b_neg;
  logic [XLEN:0]   r_shift, diff;

  // Next-state: latch magnitudes on start, one restoring step per RUN cycle
  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rem_sel_d = rem_sel_q;

    a_neg   = iSigned & iA[XLEN-1];
    b_neg   = iSigned & iB[XLEN-1];
    r_shift = {rem_q, quo_q[XLEN-1]};
    diff    = r_shift - {1'b0, dvsr_q};

    case (state_q)
      IDLE: begin
        if (iStart && !iAbort) begin
          state_d   = RUN;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_neg ? -iA : iA;
          dvsr_d    = b_neg ? -iB : iB;
          // Divide by zero keeps the all-ones quotient the magnitude loop produces
          q_neg_d   = (a_neg ^ b_neg) && (iB != '0);
          r_neg_d   = a_neg;
          rem_sel_d = iRem;
        end
      end
      RUN: begin
        if (iAbort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (!diff[XLEN]) rem_d = diff[XLEN-1:0];
          else             rem_d = r_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (iAbort || !iHold) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Divider state registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  assign oBusy   = (state_q == RUN) || (state_q == DONE);
  assign oDone   = (state_q == DONE);
  assign oResult = rem_sel_q ? (r_neg_q ? -rem_q : rem_q)
                             : (q_neg_q ? -quo_q : quo_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, multiplier and branch resolution, plus an
// iterative divider that stalls the front end while it runs.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       iClk,
  input  logic       nRst,
  ex_stage_if.slave  bus
);

  id_ex_t          id;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_res;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic            mul_a_signed, mul_b_signed;
  logic            br_taken, take;
  logic [XLEN-1:0] tgt_raw, tgt;
  logic [XLEN-1:0] ex_value;
  logic            is_div, div_start, div_busy, div_done;
  logic [XLEN-1:0] div_result;

  ex_mem_t         me_q, me_d;
  ex_mem_t         pend_q, pend_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] target_q, target_d;

  assign id = bus.iID;

  // Multiplier: sign-extend to 2*XLEN so one unsigned product serves all four ops
  always_comb begin
    mul_a_signed = id.ctrl.alu_op inside {OP_MULH, OP_MULHSU};
    mul_b_signed = (id.ctrl.alu_op == OP_MULH);
    mul_a    = {{XLEN{mul_a_signed & id.rs1[XLEN-1]}}, id.rs1};
    mul_b    = {{XLEN{mul_b_signed & id.rs2[XLEN-1]}}, id.rs2};
    mul_prod = mul_a * mul_b;
    mul_res  = (id.ctrl.alu_op == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // Integer ALU with rs2/imm operand select
  always_comb begin
    op_b    = id.ctrl.use_imm ? id.imm : id.rs2;
    alu_res = mul_res;
    case (id.ctrl.alu_op)
      OP_ADD:  alu_res = id.rs1 + op_b;
      OP_SUB:  alu_res = id.rs1 - op_b;
      OP_SLL:  alu_res = id.rs1 << op_b[4:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(id.rs1) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, id.rs1 < op_b};
      OP_XOR:  alu_res = id.rs1 ^ op_b;
      OP_SRL:  alu_res = id.rs1 >> op_b[4:0];
      OP_SRA:  alu_res = $signed(id.rs1) >>> op_b[4:0];
      OP_OR:   alu_res = id.rs1 | op_b;
      OP_AND:  alu_res = id.rs1 & op_b;
      default: alu_res = mul_res;
    endcase
  end

  // Branch/jump resolution and the value written back
  always_comb begin
    case (id.ctrl.func3)
      F3_BEQ:  br_taken = (id.rs1 == id.rs2);
      F3_BNE:  br_taken = (id.rs1 != id.rs2);
      F3_BLT:  br_taken = ($signed(id.rs1) <  $signed(id.rs2));
      F3_BGE:  br_taken = ($signed(id.rs1) >= $signed(id.rs2));
      F3_BLTU: br_taken = (id.rs1 <  id.rs2);
      F3_BGEU: br_taken = (id.rs1 >= id.rs2);
      default: br_taken = 1'b0;
    endcase
    take    = id.ctrl.valid && (id.ctrl.jal || id.ctrl.jalr || (id.ctrl.branch && br_taken));
    tgt_raw = id.ctrl.jalr ? (id.rs1 + id.imm) : (id.pc + id.imm);
    tgt     = tgt_raw & ~XLEN'(1);

    ex_value = alu_res;
    if (id.ctrl.mem_en)               ex_value = id.rs1 + id.imm;
    if (id.ctrl.jal || id.ctrl.jalr)  ex_value = id.pc + XLEN'(4);
  end

  assign is_div    = id.ctrl.valid && is_div_op(id.ctrl.alu_op);
  assign div_start = is_div && !bus.iStall && !bus.iFlush && !div_busy;

  ex_divider u_div (
    .iClk    (iClk),
    .nRst    (nRst),
    .iStart  (div_start),
    .iSigned (id.ctrl.alu_op inside {OP_DIV, OP_REM}),
    .iRem    (id.ctrl.alu_op inside {OP_REM, OP_REMU}),
    .iA      (id.rs1),
    .iB      (id.rs2),
    .iAbort  (bus.iFlush),
    .iHold   (bus.iStall),
    .oBusy   (div_busy),
    .oDone   (div_done),
    .oResult (div_result)
  );

  // Output register update: flush first, then stall, then whatever the divider permits
  always_comb begin
    me_d       = me_q;
    pend_d     = pend_q;
    redirect_d = redirect_q;
    target_d   = target_q;
    if (bus.iFlush) begin
      me_d       = '0;
      redirect_d = 1'b0;
    end else if (!bus.iStall) begin
      if (div_done) begin
        me_d          = pend_q;
        me_d.rd.value = div_result;
        redirect_d    = 1'b0;
      end else if (!div_busy) begin
        if (is_div) begin
          // Bubble goes out now; the op's identity waits in pend_q for the result
          me_d              = '0;
          redirect_d        = 1'b0;
          pend_d.ctrl       = id.ctrl;
          pend_d.rd.addr    = id.rd_addr;
          pend_d.rd.value   = '0;
          pend_d.rs.value   = id.rs2;
        end else begin
          me_d.ctrl     = id.ctrl;
          me_d.rd.addr  = id.rd_addr;
          me_d.rd.value = ex_value;
          me_d.rs.value = id.rs2;
          redirect_d    = take;
          target_d      = tgt;
        end
      end
    end
  end

  // Output and pending-op registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      me_q       <= '0;
      pend_q     <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      me_q       <= me_d;
      pend_q     <= pend_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  assign bus.oME       = me_q;
  assign bus.oRedirect = redirect_q;
  assign bus.oTarget   = target_q;
  assign bus.oStall    = div_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage dut (.iClk(clk), .nRst(nRst), .bus(bus));

  int checks = 0;
  int errors = 0;

  initial begin
    #300000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic id_ex_t mk(alu_op_e op, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic use_imm);
    id_ex_t t;
    t = '0;
    t.ctrl.valid   = 1'b1;
    t.ctrl.alu_op  = op;
    t.ctrl.use_imm = use_imm;
    t.ctrl.wb_en   = 1'b1;
    t.pc           = 32'h0000_1000;
    t.rs1          = rs1;
    t.rs2          = rs2;
    t.imm          = imm;
    t.rd_addr      = 5'($urandom_range(1, 31));
    return t;
  endfunction

  // Reference: architectural result of one op
  function automatic logic [31:0] ref_value(id_ex_t t);
    logic [31:0] a, b;
    logic [63:0] p;
    int sa, sb;
    longint la, lb;
    longint unsigned ua, ub;
    a  = t.rs1;
    b  = (t.ctrl.use_imm && t.ctrl.alu_op < OP_MUL) ? t.imm : t.rs2;
    sa = $signed(a);
    sb = $signed(b);
    la = sa;
    lb = sb;
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (t.ctrl.jal || t.ctrl.jalr) return t.pc + 32'd4;
    if (t.ctrl.mem_en) return t.rs1 + t.imm;
    case (t.ctrl.alu_op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_SLL:    return a << b[4:0];
      OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:    return a ^ b;
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    return 32'(sa >>> b[4:0]);
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = la * lb; return p[63:32]; end
      OP_MULHSU: begin p = la * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic ref_redirect(id_ex_t t);
    int x, y;
    logic tk;
    x = $signed(t.rs1);
    y = $signed(t.rs2);
    case (t.ctrl.func3)
      F3_BEQ:  tk = (t.rs1 == t.rs2);
      F3_BNE:  tk = (t.rs1 != t.rs2);
      F3_BLT:  tk = (x < y);
      F3_BGE:  tk = (x >= y);
      F3_BLTU: tk = (t.rs1 < t.rs2);
      F3_BGEU: tk = (t.rs1 >= t.rs2);
      default: tk = 1'b0;
    endcase
    return t.ctrl.valid && (t.ctrl.jal || t.ctrl.jalr || (t.ctrl.branch && tk));
  endfunction

  function automatic logic [31:0] ref_target(id_ex_t t);
    logic [31:0] v;
    v = t.ctrl.jalr ? (t.rs1 + t.imm) : (t.pc + t.imm);
    v[0] = 1'b0;
    return v;
  endfunction

  task automatic test_reset;
    nRst = 1'b0;
    #12;
    checks++;
    if (bus.oME !== '0 || bus.oRedirect !== 1'b0 || bus.oTarget !== 32'd0 || bus.oStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state me=%h redir=%b tgt=%h stall=%b required all zero",
               bus.oME, bus.oRedirect, bus.oTarget, bus.oStall);
    end
    @(negedge clk);
    nRst = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    id_ex_t t;
    logic [31:0] exp;
    t = mk(OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0);
    bus.iID = t;
    tick;
    checks++;
    if (bus.oME.rd.value !== 32'd12 || bus.oStall !== 1'b0) begin
      errors++;
      $display("FAIL add_5_7 value=%h stall=%b required 0000000c stall=0", bus.oME.rd.value, bus.oStall);
    end
    t = mk(OP_SRA, 32'hF000_0000, 32'd0, 32'd4, 1'b1);
    bus.iID = t;
    tick;
    checks++;
    if (bus.oME.rd.value !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL sra_imm4 value=%h required ff000000", bus.oME.rd.value);
    end
    for (int i = 0; i < 60; i++) begin
      t = mk(alu_op_e'(5'($urandom_range(0, 13))), $urandom, $urandom, $urandom, 1'($urandom));
      bus.iID = t;
      exp = ref_value(t);
      tick;
      checks++;
      if (bus.oME.rd.value !== exp || bus.oME.rd.addr !== t.rd_addr || bus.oME.ctrl !== t.ctrl) begin
        errors++;
        $display("FAIL alu_random op=%0d a=%h b=%h imm=%h ui=%b got %h/%0d required %h/%0d",
                 t.ctrl.alu_op, t.rs1, t.rs2, t.imm, t.ctrl.use_imm,
                 bus.oME.rd.value, bus.oME.rd.addr, exp, t.rd_addr);
      end
      checks++;
      if (bus.oStall !== 1'b0 || bus.oRedirect !== 1'b0) begin
        errors++;
        $display("FAIL alu_side_effects stall=%b redir=%b required 0 0", bus.oStall, bus.oRedirect);
      end
    end
  endtask

  task automatic test_mem;
    id_ex_t t;
    for (int i = 0; i < 10; i++) begin
      t = mk(OP_ADD, $urandom, $urandom, $urandom, 1'b1);
      t.ctrl.mem_en = 1'b1;
      t.ctrl.wb_en  = 1'($urandom);
      bus.iID = t;
      tick;
      checks++;
      if (bus.oME.rd.value !== t.rs1 + t.imm || bus.oME.rs.value !== t.rs2 ||
          bus.oME.ctrl.mem_en !== 1'b1 || bus.oME.ctrl.wb_en !== t.ctrl.wb_en) begin
        errors++;
        $display("FAIL mem_op addr=%h data=%h wb=%b required %h %h %b",
                 bus.oME.rd.value, bus.oME.rs.value, bus.oME.ctrl.wb_en,
                 t.rs1 + t.imm, t.rs2, t.ctrl.wb_en);
      end
    end
  endtask

  task automatic test_branch;
    id_ex_t t;
    logic [2:0] codes [6];
    logic exp_r;
    int kind;
    codes = '{F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
    t = mk(OP_ADD, 32'd3, 32'd3, 32'h20, 1'b0);
    t.ctrl.branch = 1'b1;
    t.ctrl.wb_en  = 1'b0;
    t.ctrl.func3  = F3_BEQ;
    t.pc          = 32'h100;
    bus.iID = t;
    tick;
    checks++;
    if (bus.oRedirect !== 1'b1 || bus.oTarget !== 32'h120) begin
      errors++;
      $display("FAIL beq_taken redir=%b tgt=%h required 1 00000120", bus.oRedirect, bus.oTarget);
    end
    t.rs2 = 32'd4;
    bus.iID = t;
    tick;
    checks++;
    if (bus.oRedirect !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_taken redir=%b required 0", bus.oRedirect);
    end
    for (int i = 0; i < 40; i++) begin
      t = mk(OP_ADD, $urandom, $urandom, $urandom, 1'b0);
      t.pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 2) == 0) t.rs2 = t.rs1;
      kind = $urandom_range(0, 3);
      t.ctrl.branch = (kind <= 1);
      t.ctrl.jal    = (kind == 2);
      t.ctrl.jalr   = (kind == 3);
      t.ctrl.func3  = codes[$urandom_range(0, 5)];
      t.ctrl.valid  = ($urandom_range(0, 4) != 0);
      bus.iID = t;
      exp_r = ref_redirect(t);
      tick;
      checks++;
      if (bus.oRedirect !== exp_r || (exp_r && bus.oTarget !== ref_target(t))) begin
        errors++;
        $display("FAIL branch_random kind=%0d f3=%0d v=%b a=%h b=%h redir=%b tgt=%h required %b %h",
                 kind, t.ctrl.func3, t.ctrl.valid, t.rs1, t.rs2, bus.oRedirect, bus.oTarget,
                 exp_r, ref_target(t));
      end
      if (t.ctrl.valid && kind >= 2) begin
        checks++;
        if (bus.oME.rd.value !== t.pc + 32'd4) begin
          errors++;
          $display("FAIL jump_link value=%h required %h", bus.oME.rd.value, t.pc + 32'd4);
        end
      end
    end
    bus.iID = '0;
    tick;
  endtask

  task automatic test_div;
    id_ex_t t;
    alu_op_e ops [6];
    logic [31:0] as [6];
    logic [31:0] bs [6];
    logic [31:0] ex [6];
    logic [31:0] exp;
    int n;
    ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd10, 32'd10, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ex  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        t = mk(ops[i], as[i], bs[i], 32'd0, 1'b0);
        exp = ex[i];
      end else begin
        t = mk(alu_op_e'(5'($urandom_range(14, 17))), $urandom,
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31),
               32'd0, 1'b0);
        if ($urandom_range(0, 1) == 0) t.rs1 = -t.rs1;
        exp = ref_value(t);
      end
      bus.iID = t;
      tick;
      checks++;
      if (bus.oME.ctrl.valid !== 1'b0 || bus.oStall !== 1'b1) begin
        errors++;
        $display("FAIL div_accept valid=%b stall=%b required 0 1", bus.oME.ctrl.valid, bus.oStall);
      end
      n = 0;
      while (bus.oStall === 1'b1 && n < 40) begin
        n++;
        tick;
      end
      bus.iID = '0;
      checks++;
      if (n != 33) begin
        errors++;
        $display("FAIL div_stall_cycles got %0d required 33", n);
      end
      checks++;
      if (bus.oME.rd.value !== exp || bus.oME.ctrl.valid !== 1'b1 || bus.oME.rd.addr !== t.rd_addr) begin
        errors++;
        $display("FAIL div_result op=%0d a=%h b=%h got %h v=%b required %h",
                 t.ctrl.alu_op, t.rs1, t.rs2, bus.oME.rd.value, bus.oME.ctrl.valid, exp);
      end
      tick;
    end
  endtask

  task automatic test_div_stall;
    id_ex_t t;
    logic [31:0] exp;
    t = mk(OP_DIV, $urandom, 32'd0 + $urandom_range(1, 1000), 32'd0, 1'b0);
    exp = ref_value(t);
    bus.iID = t;
    tick;
    for (int i = 0; i < 32; i++) begin
      bus.iStall = (i >= 5 && i < 10);
      tick;
    end
    bus.iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (bus.oME !== '0 || bus.oStall !== 1'b1) begin
        errors++;
        $display("FAIL div_done_hold cyc=%0d me=%h stall=%b required bubble stall=1", i, bus.oME, bus.oStall);
      end
    end
    bus.iStall = 1'b0;
    tick;
    bus.iID = '0;
    checks++;
    if (bus.oStall !== 1'b0 || bus.oME.rd.value !== exp || bus.oME.ctrl.valid !== 1'b1) begin
      errors++;
      $display("FAIL div_release stall=%b value=%h required 0 %h", bus.oStall, bus.oME.rd.value, exp);
    end
    tick;
  endtask

  task automatic test_flush;
    id_ex_t t;
    t = mk(OP_DIVU, $urandom, $urandom, 32'd0, 1'b0);
    bus.iID = t;
    tick;
    repeat (9) tick;
    bus.iFlush = 1'b1;
    bus.iID = '0;
    tick;
    bus.iFlush = 1'b0;
    checks++;
    if (bus.oStall !== 1'b0 || bus.oME.ctrl.valid !== 1'b0) begin
      errors++;
      $display("FAIL div_flush stall=%b valid=%b required 0 0", bus.oStall, bus.oME.ctrl.valid);
    end
    t = mk(OP_ADD, $urandom, $urandom, 32'd0, 1'b0);
    bus.iID = t;
    tick;
    checks++;
    if (bus.oME.rd.value !== t.rs1 + t.rs2 || bus.oME.ctrl.valid !== 1'b1 || bus.oStall !== 1'b0) begin
      errors++;
      $display("FAIL add_after_flush value=%h required %h", bus.oME.rd.value, t.rs1 + t.rs2);
    end
    t = mk(OP_ADD, 32'd0, 32'd0, 32'h40, 1'b0);
    t.ctrl.jal = 1'b1;
    bus.iID = t;
    bus.iFlush = 1'b1;
    tick;
    bus.iFlush = 1'b0;
    bus.iID = '0;
    checks++;
    if (bus.oRedirect !== 1'b0 || bus.oME.ctrl.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_squash_jal redir=%b valid=%b required 0 0", bus.oRedirect, bus.oME.ctrl.valid);
    end
    tick;
  endtask

  task automatic test_reset_mid_div;
    id_ex_t t;
    t = mk(OP_ADD, 32'd0, 32'd0, 32'h40, 1'b0);
    t.ctrl.jal = 1'b1;
    t.pc = 32'h200;
    bus.iID = t;
    tick;
    checks++;
    if (bus.oRedirect !== 1'b1 || bus.oTarget !== 32'h240) begin
      errors++;
      $display("FAIL jal_before_reset redir=%b tgt=%h required 1 00000240", bus.oRedirect, bus.oTarget);
    end
    bus.iID = mk(OP_REM, $urandom, $urandom, 32'd0, 1'b0);
    tick;
    repeat (5) tick;
    #2;
    nRst = 1'b0;
    #1;
    checks++;
    if (bus.oME !== '0 || bus.oRedirect !== 1'b0 || bus.oTarget !== 32'd0 || bus.oStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div me=%h redir=%b tgt=%h stall=%b required all zero",
               bus.oME, bus.oRedirect, bus.oTarget, bus.oStall);
    end
    bus.iID = '0;
    @(negedge clk);
    nRst = 1'b1;
    t = mk(OP_ADD, $urandom, $urandom, 32'd0, 1'b0);
    bus.iID = t;
    tick;
    checks++;
    if (bus.oME.rd.value !== t.rs1 + t.rs2 || bus.oStall !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset value=%h required %h", bus.oME.rd.value, t.rs1 + t.rs2);
    end
  endtask

  initial begin
    bus.iStall = 1'b0;
    bus.iFlush = 1'b0;
    bus.iID    = '0;
    test_reset;
    test_alu;
    test_mem;
    test_branch;
    test_div;
    test_div_stall;
    test_flush;
    test_reset_mid_div;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
